// File: rtl/csr_regfile_if.sv
// CSR access port between the CSR execution unit (master) and the register file (slave):
// a same-cycle read port and a commit-time write port.
interface csr_regfile_if #(
    parameter int XLEN = 64
);
    logic            read_valid;
    logic [11:0]     read_addr;
    logic [XLEN-1:0] read_data;
    logic            read_illegal;
    logic            write_valid;
    logic [11:0]     write_addr;
    logic [XLEN-1:0] write_data;

    modport master (
        output read_valid, read_addr, write_valid, write_addr, write_data,
        input  read_data, read_illegal
    );

    modport slave (
        input  read_valid, read_addr, write_valid, write_addr, write_data,
        output read_data, read_illegal
    );
endinterface

// File: rtl/csr_regfile.sv
// Architectural CSR storage for one hart: FP control/flags, machine trap CSRs,
// free-running cycle/instret counters, and exported control values.
module csr_regfile #(
    parameter int              XLEN            = 64,
    parameter int              NUM_OF_GRADUATE = 2,
    parameter logic [XLEN-1:0] HART_ID         = '0,
    parameter logic [XLEN-1:0] MISA_VAL        = 64'h8000_0000_0014_1101
) (
    input  logic                       clock,
    input  logic                       reset,
    csr_regfile_if.slave               csr,
    input  logic [NUM_OF_GRADUATE-1:0] commit_valid,
    input  logic                       fflags_accrue_valid,
    input  logic [4:0]                 fflags_accrue,
    input  logic                       trap_valid,
    input  logic [XLEN-1:0]            trap_cause,
    input  logic [XLEN-1:0]            trap_epc,
    input  logic [XLEN-1:0]            trap_tval,
    input  logic                       mret_valid,
    output logic [XLEN-1:0]            mtvec_out,
    output logic [XLEN-1:0]            mepc_out,
    output logic [2:0]                 frm_out,
    output logic                       mie_out
);
    localparam logic [11:0] A_FFLAGS   = 12'h001;
    localparam logic [11:0] A_FRM      = 12'h002;
    localparam logic [11:0] A_FCSR     = 12'h003;
    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MISA     = 12'h301;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MTVAL    = 12'h343;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MINSTRET = 12'hB02;
    localparam logic [11:0] A_CYCLE    = 12'hC00;
    localparam logic [11:0] A_INSTRET  = 12'hC02;
    localparam logic [11:0] A_MHARTID  = 12'hF14;

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    logic [7:0]      fcsr;
    logic            mie;
    logic            mpie;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mscratch;
    logic [XLEN-1:0] mepc;
    logic [XLEN-1:0] mcause;
    logic [XLEN-1:0] mtval;
    logic [XLEN-1:0] mcycle;
    logic [XLEN-1:0] minstret;

    logic [7:0]      fcsr_next;
    logic [XLEN-1:0] retire_cnt;
    logic [XLEN-1:0] rd_value;
    logic            rd_legal;
    logic [XLEN-1:0] mstatus_view;

    function automatic logic wr_hit(input logic [11:0] addr);
        return csr.write_valid && (csr.write_addr == addr);
    endfunction

    always_comb begin
        mstatus_view        = '0;
        mstatus_view[12:11] = 2'b11;
        mstatus_view[7]     = mpie;
        mstatus_view[3]     = mie;
    end

    always_comb begin
        rd_value = '0;
        rd_legal = 1'b1;
        case (csr.read_addr)
            A_FFLAGS:              rd_value = XLEN'(fcsr[4:0]);
            A_FRM:                 rd_value = XLEN'(fcsr[7:5]);
            A_FCSR:                rd_value = XLEN'(fcsr);
            A_MSTATUS:             rd_value = mstatus_view;
            A_MISA:                rd_value = MISA_VAL;
            A_MTVEC:               rd_value = mtvec;
            A_MSCRATCH:            rd_value = mscratch;
            A_MEPC:                rd_value = mepc;
            A_MCAUSE:              rd_value = mcause;
            A_MTVAL:               rd_value = mtval;
            A_MCYCLE, A_CYCLE:     rd_value = mcycle;
            A_MINSTRET, A_INSTRET: rd_value = minstret;
            A_MHARTID:             rd_value = HART_ID;
            default:               rd_legal = 1'b0;
        endcase
        csr.read_data    = (csr.read_valid && rd_legal) ? rd_value : '0;
        csr.read_illegal = csr.read_valid && !rd_legal;
    end

    // The CSR write lands first; accrued flags are ORed on top so none are lost.
    always_comb begin
        fcsr_next = fcsr;
        if (wr_hit(A_FFLAGS)) fcsr_next[4:0] = csr.write_data[4:0];
        if (wr_hit(A_FRM))    fcsr_next[7:5] = csr.write_data[2:0];
        if (wr_hit(A_FCSR))   fcsr_next      = csr.write_data[7:0];
        if (fflags_accrue_valid) fcsr_next[4:0] = fcsr_next[4:0] | fflags_accrue;
    end

    always_comb begin
        retire_cnt = '0;
        for (int i = 0; i < NUM_OF_GRADUATE; i++)
            retire_cnt = retire_cnt + XLEN'(commit_valid[i]);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fcsr     <= '0;
            mie      <= 1'b0;
            mpie     <= 1'b0;
            mtvec    <= '0;
            mscratch <= '0;
            mepc     <= '0;
            mcause   <= '0;
            mtval    <= '0;
            mcycle   <= '0;
            minstret <= '0;
        end else begin
            fcsr <= fcsr_next;

            if (wr_hit(A_MTVEC))    mtvec    <= csr.write_data & ALIGN_MASK;
            if (wr_hit(A_MSCRATCH)) mscratch <= csr.write_data;

            // Trap outranks mret, which outranks a software write.
            if (trap_valid) begin
                mpie   <= mie;
                mie    <= 1'b0;
                mepc   <= trap_epc & ALIGN_MASK;
                mcause <= trap_cause;
                mtval  <= trap_tval;
            end else begin
                if (mret_valid) begin
                    mie  <= mpie;
                    mpie <= 1'b1;
                end else if (wr_hit(A_MSTATUS)) begin
                    mie  <= csr.write_data[3];
                    mpie <= csr.write_data[7];
                end
                if (wr_hit(A_MEPC))   mepc   <= csr.write_data & ALIGN_MASK;
                if (wr_hit(A_MCAUSE)) mcause <= csr.write_data;
                if (wr_hit(A_MTVAL))  mtval  <= csr.write_data;
            end

            mcycle   <= wr_hit(A_MCYCLE)   ? csr.write_data : mcycle + XLEN'(1);
            minstret <= wr_hit(A_MINSTRET) ? csr.write_data : minstret + retire_cnt;
        end
    end

    assign mtvec_out = mtvec;
    assign mepc_out  = mepc;
    assign frm_out   = fcsr[7:5];
    assign mie_out   = mie;
endmodule

// File: doc/csr_regfile.md
# csr_regfile

Architectural CSR storage for one hart, directly downstream of the CSR execution unit. It services that unit's same-cycle read port and its commit-time write port. It also owns the free-running counters, FP-flag accrual from committed FP ops, and trap/mret updates to the machine trap CSRs. Control values (mtvec, mepc, frm, MIE) are exported to the front end, FPU and trap logic.

## Interface
- XLEN, 64, data width of all CSRs.
- NUM_OF_GRADUATE, 2, commit slots per cycle feeding minstret.
- HART_ID, 0, value returned by mhartid.
- MISA_VAL, 64'h8000_0000_0014_1101, value returned by misa.

- clock  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- read_valid  in  1  read request qualifier
- read_addr  in  12  CSR address to read
- read_data  out  XLEN  combinational read value; 0 when read_valid=0 or address illegal
- read_illegal  out  1  read_valid=1 and address not implemented
- write_valid  in  1  commit-time CSR write
- write_addr  in  12  CSR address to write
- write_data  in  XLEN  full new value (RMW already done upstream)
- commit_valid  in  NUM_OF_GRADUATE  per-slot retirement strobes
- fflags_accrue_valid  in  1  FP exception flags from committed FP ops
- fflags_accrue  in  5  flags to OR into fflags
- trap_valid  in  1  take trap this cycle
- trap_cause  in  XLEN  value for mcause
- trap_epc  in  XLEN  value for mepc
- trap_tval  in  XLEN  value for mtval
- mret_valid  in  1  execute mret
- mtvec_out, mepc_out  out  XLEN  registered CSR values
- frm_out  out  3  registered rounding mode
- mie_out  out  1  registered mstatus.MIE

## Operation
- Implemented addresses: fflags 0x001, frm 0x002, fcsr 0x003, mstatus 0x300, misa 0x301, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mcycle 0xB00, minstret 0xB02, cycle 0xC00, instret 0xC02, mhartid 0xF14. Any other address is illegal.
- fcsr is a single 8-bit register. fflags = fcsr[4:0], frm = fcsr[7:5]. Reading fcsr zero-extends bits [7:0].
  - Writing fflags updates only [4:0]; writing frm updates only [7:5]; writing fcsr updates [7:0]. Upper write bits are dropped.
- mstatus: only MIE (bit 3) and MPIE (bit 7) are stored. MPP [12:11] always reads 2'b11. All other bits read 0, and writes to them are dropped.
- mtvec and mepc: bits [1:0] are forced to 0 on every write path.
- Read-only addresses (misa, cycle, instret, mhartid): writes are silently ignored. Illegal-address writes are ignored.
- cycle and instret read the same values as mcycle and minstret.
- mcycle increments by 1 every cycle. minstret increments by popcount(commit_valid), 0..NUM_OF_GRADUATE. Both wrap modulo 2^XLEN.
- Trap: mepc <= trap_epc (low bits cleared), mcause <= trap_cause, mtval <= trap_tval, MPIE <= MIE, MIE <= 0.
- mret: MIE <= MPIE, MPIE <= 1.
- Same-cycle priority, per register:
  - trap > mret > CSR write, for mstatus/mepc/mcause/mtval. Asserting trap_valid and mret_valid together means mret is ignored.
  - A CSR write to mcycle or minstret replaces that cycle's increment.
  - fflags: the CSR write is applied first, then fflags_accrue is ORed on top. Accrued flags are never lost.
- Reads are purely combinational from current register state. A read and a write to the same address in the same cycle return the pre-write value.

## Timing
- Read latency 0 (same cycle). Writes, traps, mret, accrual and increments take effect at the next posedge, so they are visible to reads one cycle later.
- Exported outputs reflect register state, so they update the cycle after the causing event.
- Reset values (asynchronous):
  - All stored CSRs are 0, including mcycle and minstret.
  - Therefore mtvec_out=0, mepc_out=0, frm_out=0, mie_out=0, read_data=0, read_illegal=0.
  - mcycle reads 0 in the first cycle after reset deassertion.
- Reset mid-operation discards any pending write or trap in that cycle.
- No handshake and no backpressure: every valid input is consumed in its cycle.

## Test plan
- Reset, release, idle 10 cycles -> mcycle and cycle read 10; minstret reads 0; mhartid reads HART_ID; misa reads MISA_VAL; address 0x7C0 gives read_illegal=1 with read_data=0.
- Write mtvec=0x8000_0103 -> next cycle mtvec reads 0x8000_0100; mtvec_out=0x8000_0100. Write cycle=5 -> cycle is unaffected and keeps counting.
- Write fcsr=0xFF, then frm=0x2 -> fcsr reads 0x5F and frm_out=2. Write fflags=0x01 in the same cycle as accrue 0x10 -> fflags reads 0x11.
- Set MIE=1; trap with cause 0xB, epc 0x1002 -> mepc=0x1000, mcause=0xB, MIE=0, MPIE=1. Then mret -> MIE=1, MPIE=1.
- Trap, mret and a CSR write of mstatus=0 all in one cycle -> only the trap's effect is visible. commit_valid=2'b11 for 3 cycles -> minstret reads 6.
- Write minstret=0xFFFF_FFFF_FFFF_FFFF while commit_valid=2'b01 -> next cycle reads all-ones. The following cycle with one commit wraps it to 0. Asserting reset during that sequence returns all state to 0 immediately.
